// File: rtl/pla_pipe_eval.sv
// Programmable sum-of-products evaluator: AND/OR planes loaded over a config port, 2-stage valid/ready evaluation pipe.
// Optional PLA_HIT_CNT_EN adds hit_cnt, a saturating count of delivered non-zero results.
module pla_pipe_eval #(
  parameter int N_IN    = 12,
  parameter int N_OUT   = 10,
  parameter int N_TERMS = 32,
  localparam int AW     = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [N_IN-1:0]  cfg_care,
  input  logic [N_IN-1:0]  cfg_pol,
  input  logic [N_OUT-1:0] cfg_or,
  input  logic             cfg_commit,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_vec,
  output logic             busy
`ifdef PLA_HIT_CNT_EN
  ,
  output logic [15:0]      hit_cnt
`endif
);

  typedef enum logic [1:0] {S_CFG, S_RUN, S_DRAIN} state_e;

  localparam logic [AW-1:0] INV_ADDR = AW'(N_TERMS);

  state_e             state_q;
  logic               cfg_ready_q;
  logic               cfg_err_q;
  logic [N_IN-1:0]    care_q [N_TERMS];
  logic [N_IN-1:0]    pol_q  [N_TERMS];
  logic [N_OUT-1:0]   or_q   [N_TERMS];
  logic [N_OUT-1:0]   inv_q;
  logic               s1_vld_q;
  logic [N_TERMS-1:0] s1_term_q;
  logic               s2_vld_q;
  logic [N_OUT-1:0]   s2_out_q;

  logic               cfg_fire;
  logic               s1_adv;
  logic               s2_adv;
  logic               in_fire;
  logic [N_TERMS-1:0] term_d;
  logic [N_OUT-1:0]   s2_out_d;

  assign cfg_fire = cfg_valid && cfg_ready_q;
  assign s2_adv   = !s2_vld_q || out_ready;
  assign s1_adv   = !s1_vld_q || s2_adv;
  assign in_ready = (state_q == S_RUN) && s1_adv;
  assign in_fire  = in_valid && in_ready;

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign out_valid = s2_vld_q;
  assign out_vec   = s2_out_q;
  assign busy      = (state_q == S_DRAIN) || s1_vld_q || s2_vld_q;

  // A literal passes when it is don't-care or matches its polarity bit.
  always_comb begin
    term_d = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      term_d[t] = &(~care_q[t] | ~(in_vec ^ pol_q[t]));
    end
  end

  always_comb begin
    s2_out_d = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      if (s1_term_q[t]) s2_out_d = s2_out_d | or_q[t];
    end
    s2_out_d = s2_out_d ^ inv_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_CFG;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_CFG: begin
          if (cfg_valid && (cfg_addr > INV_ADDR)) cfg_err_q <= 1'b1;
          if (cfg_commit) begin
            state_q     <= S_RUN;
            cfg_ready_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (cfg_valid) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!s1_vld_q && !s2_vld_q) begin
            state_q     <= S_CFG;
            cfg_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_CFG;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Writes only land in CFG, so the planes never change under a vector in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int t = 0; t < N_TERMS; t++) begin
        care_q[t] <= '0;
        pol_q[t]  <= '0;
        or_q[t]   <= '0;
      end
      inv_q <= '0;
    end else if (cfg_fire) begin
      for (int t = 0; t < N_TERMS; t++) begin
        if (cfg_addr == AW'(t)) begin
          care_q[t] <= cfg_care;
          pol_q[t]  <= cfg_pol;
          or_q[t]   <= cfg_or;
        end
      end
      if (cfg_addr == INV_ADDR) inv_q <= cfg_or;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_term_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_out_q  <= '0;
    end else begin
      if (s1_adv) begin
        s1_vld_q <= in_fire;
        if (in_fire) s1_term_q <= term_d;
      end
      if (s2_adv) begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) s2_out_q <= s2_out_d;
      end
    end
  end

`ifdef PLA_HIT_CNT_EN
  logic [15:0] hit_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q <= '0;
    end else if ((state_q == S_CFG) && cfg_commit) begin
      hit_q <= '0;
    end else if (s2_vld_q && out_ready && (|s2_out_q) && (hit_q != 16'hFFFF)) begin
      hit_q <= hit_q + 16'd1;
    end
  end

  assign hit_cnt = hit_q;
`endif

endmodule

// File: tb/tb_pla_pipe_eval.sv
// Bench for pla_pipe_eval: constant-table vectors, directed pipeline/config corner cases, randomized scoreboard run.
module tb_pla_pipe_eval;
  localparam int NI = 12;
  localparam int NO = 10;
  localparam int NT = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [NI-1:0] cfg_care;
  logic [NI-1:0] cfg_pol;
  logic [NO-1:0] cfg_or;
  logic          cfg_commit;
  logic          cfg_err;
  logic          in_valid;
  logic          in_ready;
  logic [NI-1:0] in_vec;
  logic          out_valid;
  logic          out_ready;
  logic [NO-1:0] out_vec;
  logic          busy;
`ifdef PLA_HIT_CNT_EN
  logic [15:0]   hit_cnt;
`endif

  always #5 clk = ~clk;

  pla_pipe_eval dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_care   (cfg_care),
    .cfg_pol    (cfg_pol),
    .cfg_or     (cfg_or),
    .cfg_commit (cfg_commit),
    .cfg_err    (cfg_err),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vec    (out_vec),
    .busy       (busy)
`ifdef PLA_HIT_CNT_EN
    ,
    .hit_cnt    (hit_cnt)
`endif
  );

  typedef struct {
    logic [NI-1:0] care;
    logic [NI-1:0] pol;
    logic [NO-1:0] orr;
    logic [NO-1:0] inv;
    logic [NI-1:0] vec;
    logic [NO-1:0] exp;
  } tv_t;

  tv_t tbl [10];

  int checks = 0;
  int errors = 0;

  logic [NI-1:0] m_care [NT];
  logic [NI-1:0] m_pol  [NT];
  logic [NO-1:0] m_or   [NT];
  logic [NO-1:0] m_inv;
  logic [NO-1:0] exp_q [$];
  logic [NO-1:0] obs_q [$];
  int            acc_cyc_q [$];
  int            cyc = 0;
  int            n_acc, n_pop, first_pop, last_pop, min_lat, max_lat;
  bit            fired_cfg;
  bit            stall_prev;
  logic [NO-1:0] stall_vec;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endfunction

  // Each output is 1 if any selected term has all its cared literals matching, then inverted.
  function automatic logic [NO-1:0] model_eval(logic [NI-1:0] v);
    logic [NO-1:0] sum;
    bit hit;
    sum = '0;
    for (int t = 0; t < NT; t++) begin
      hit = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (m_care[t][i] && (v[i] != m_pol[t][i])) hit = 1'b0;
      end
      if (hit) sum = sum | m_or[t];
    end
    return sum ^ m_inv;
  endfunction

  function automatic void model_clear();
    for (int t = 0; t < NT; t++) begin
      m_care[t] = '0;
      m_pol[t]  = '0;
      m_or[t]   = '0;
    end
    m_inv = '0;
    exp_q.delete();
    acc_cyc_q.delete();
    stall_prev = 1'b0;
  endfunction

  function automatic void stats_clear();
    n_acc = 0;
    n_pop = 0;
    first_pop = -1;
    last_pop = -1;
    min_lat = 1000;
    max_lat = 0;
    obs_q.delete();
  endfunction

  // Inputs are set just after an edge; this samples handshakes for the coming edge, then advances.
  task automatic cycle();
    int a;
    int lat;
    #1;
    fired_cfg = 1'b0;
    if (stall_prev) begin
      check("hold_vld", 32'(out_valid), 32'd1);
      check("hold_vec", 32'(out_vec), 32'(stall_vec));
    end
    if (cfg_valid && cfg_ready) begin
      fired_cfg = 1'b1;
      a = int'(cfg_addr);
      if (a < NT) begin
        m_care[a] = cfg_care;
        m_pol[a]  = cfg_pol;
        m_or[a]   = cfg_or;
      end else if (a == NT) begin
        m_inv = cfg_or;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model_eval(in_vec));
      acc_cyc_q.push_back(cyc);
      n_acc++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail("spurious_out");
      end else begin
        lat = cyc - acc_cyc_q.pop_front();
        check("out_vec", 32'(out_vec), 32'(exp_q.pop_front()));
        obs_q.push_back(out_vec);
        if (lat < min_lat) min_lat = lat;
        if (lat > max_lat) max_lat = lat;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        n_pop++;
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_vec  = out_vec;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
    in_valid   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic cfg_write(logic [AW-1:0] addr, logic [NI-1:0] care, logic [NI-1:0] pol, logic [NO-1:0] orr);
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_care  = care;
    cfg_pol   = pol;
    cfg_or    = orr;
    for (int k = 0; k < 60; k++) begin
      cycle();
      if (fired_cfg) break;
    end
    if (!fired_cfg) fail("cfg_write_timeout");
    cfg_valid = 1'b0;
  endtask

  task automatic do_commit();
    cfg_commit = 1'b1;
    cycle();
    cfg_commit = 1'b0;
  endtask

  task automatic drain_out(int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < budget; k++) begin
      if (exp_q.size() == 0) break;
      cycle();
    end
    if (exp_q.size() != 0) fail("drain_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int prev;
    bit pending;
    tbl[0] = '{12'h001, 12'h000, 10'h008, 10'h000, 12'h000, 10'h008};
    tbl[1] = '{12'h001, 12'h000, 10'h008, 10'h000, 12'h001, 10'h000};
    tbl[2] = '{12'h000, 12'h000, 10'h000, 10'h004, 12'hABC, 10'h004};
    tbl[3] = '{12'h003, 12'h002, 10'h3FF, 10'h000, 12'h000, 10'h000};
    tbl[4] = '{12'h003, 12'h002, 10'h3FF, 10'h000, 12'h001, 10'h000};
    tbl[5] = '{12'h003, 12'h002, 10'h3FF, 10'h000, 12'h002, 10'h3FF};
    tbl[6] = '{12'h003, 12'h002, 10'h3FF, 10'h000, 12'h003, 10'h000};
    tbl[7] = '{12'h000, 12'h000, 10'h155, 10'h0FF, 12'h123, 10'h1AA};
    tbl[8] = '{12'hFFF, 12'hA5A, 10'h200, 10'h000, 12'hA5A, 10'h200};
    tbl[9] = '{12'hFFF, 12'hA5A, 10'h200, 10'h000, 12'hA5B, 10'h000};

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_addr = '0;
    cfg_care = '0; cfg_pol = '0; cfg_or = '0;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
    model_clear();
    stats_clear();
    do_reset();

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_vec",   32'(out_vec),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_cfg_err",   32'(cfg_err),   32'd0);

    // Single-term vectors, each from a fresh reset, with exact 2-cycle latency.
    for (int r = 0; r < 10; r++) begin
      do_reset();
      cfg_write(6'd0, tbl[r].care, tbl[r].pol, tbl[r].orr);
      cfg_write(AW'(NT), '0, '0, tbl[r].inv);
      do_commit();
      stats_clear();
      out_ready = 1'b1;
      in_vec = tbl[r].vec;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      check($sformatf("tbl%0d_acc", r), 32'(n_acc), 32'd1);
      check($sformatf("tbl%0d_vld_early", r), 32'(out_valid), 32'd0);
      cycle();
      check($sformatf("tbl%0d_vld", r), 32'(out_valid), 32'd1);
      check($sformatf("tbl%0d_vec", r), 32'(out_vec), 32'(tbl[r].exp));
      cycle();
      check($sformatf("tbl%0d_lat", r), 32'(min_lat), 32'd2);
    end

    // Write and commit in the same cycle: write lands, then RUN.
    do_reset();
    cfg_valid = 1'b1; cfg_addr = 6'd0; cfg_care = '0; cfg_pol = '0; cfg_or = 10'h0F0;
    cfg_commit = 1'b1;
    cycle();
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    check("wc_fired", 32'(fired_cfg), 32'd1);
    check("wc_cfg_ready", 32'(cfg_ready), 32'd0);
    check("wc_in_ready", 32'(in_ready), 32'd1);
    stats_clear();
    in_vec = 12'h5A5; in_valid = 1'b1;
    cycle();
    drain_out(10);
    check("wc_result", 32'(obs_q[0]), 32'h0F0);

    // Back-to-back stream at full rate.
    do_reset();
    cfg_write(6'd0, 12'h003, 12'h002, 10'h3FF);
    do_commit();
    stats_clear();
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      in_vec = NI'(v);
      in_valid = 1'b1;
      #1;
      check($sformatf("bb_in_ready%0d", v), 32'(in_ready), 32'd1);
      cycle();
    end
    drain_out(10);
    check("bb_pops", 32'(n_pop), 32'd4);
    check("bb_consec", 32'(last_pop - first_pop), 32'd3);
    check("bb_lat_max", 32'(max_lat), 32'd2);
    check("bb_o2", 32'(obs_q[2]), 32'h3FF);
    check("bb_o3", 32'(obs_q[3]), 32'h000);

    // Output stall: only two vectors fit, then release delivers all four in order.
    stats_clear();
    out_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_vec = NI'(idx);
      prev = n_acc;
      cycle();
      if (n_acc != prev) idx++;
    end
    check("st_accepted", 32'(n_acc), 32'd2);
    check("st_in_ready", 32'(in_ready), 32'd0);
    check("st_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (idx == 4 && exp_q.size() == 0) break;
      in_valid = (idx < 4);
      in_vec = NI'(idx);
      prev = n_acc;
      cycle();
      if (n_acc != prev) idx++;
    end
    in_valid = 1'b0;
    check("st_pops", 32'(n_pop), 32'd4);
    check("st_consec", 32'(last_pop - first_pop), 32'd3);
    check("st_o2", 32'(obs_q[2]), 32'h3FF);
    check("st_o0", 32'(obs_q[0]), 32'h000);

    // Config request in RUN with two vectors in flight, to an out-of-range address.
    stats_clear();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (n_acc == 2) break;
      in_valid = 1'b1;
      in_vec = 12'h002;
      cycle();
    end
    in_valid = 1'b0;
    check("dr_inflight", 32'(n_acc), 32'd2);
    cfg_valid = 1'b1; cfg_addr = AW'(NT + 1); cfg_care = 12'hFFF; cfg_pol = 12'h000; cfg_or = 10'h3FF;
    cycle();
    check("dr_busy", 32'(busy), 32'd1);
    check("dr_cfg_ready", 32'(cfg_ready), 32'd0);
    check("dr_in_ready", 32'(in_ready), 32'd0);
    cycle();
    cycle();
    check("dr_cfg_ready_hold", 32'(cfg_ready), 32'd0);
    check("dr_cfg_err_pre", 32'(cfg_err), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (fired_cfg) break;
    end
    if (!fired_cfg) fail("dr_cfg_timeout");
    check("dr_pops_before_cfg", 32'(n_pop), 32'd2);
    cfg_valid = 1'b0;
    check("dr_cfg_err", 32'(cfg_err), 32'd1);
    check("dr_cfg_state", 32'(cfg_ready), 32'd1);
    check("dr_busy_done", 32'(busy), 32'd0);

    // Reset while a result is waiting at the output.
    do_commit();
    stats_clear();
    out_ready = 1'b0;
    in_vec = 12'h002; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("mr_vld_before", 32'(out_valid), 32'd1);
    do_reset();
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_cfg_ready", 32'(cfg_ready), 32'd1);
    check("mr_out_vec", 32'(out_vec), 32'd0);
    check("mr_cfg_err", 32'(cfg_err), 32'd0);
`ifdef PLA_HIT_CNT_EN
    check("mr_hit_cnt", 32'(hit_cnt), 32'd0);
`endif
    do_commit();
    stats_clear();
    in_vec = 12'hABC; in_valid = 1'b1;
    cycle();
    in_vec = 12'h002;
    cycle();
    drain_out(10);
    check("mr_res0", 32'(obs_q[0]), 32'd0);
    check("mr_res1", 32'(obs_q[1]), 32'd0);

    // Randomized planes and traffic against the model, reconfiguring through DRAIN between rounds.
    do_reset();
    for (int round = 0; round < 3; round++) begin
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int w = 0; w < 8; w++) begin
        cfg_write(AW'($urandom_range(0, NT - 1)), NI'($urandom & $urandom & $urandom),
                  NI'($urandom), NO'($urandom));
      end
      cfg_write(AW'(NT), '0, '0, NO'($urandom));
      do_commit();
      pending = 1'b0;
      for (int k = 0; k < 200; k++) begin
        if (!pending) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_vec = ($urandom_range(0, 1) == 1) ? m_pol[$urandom_range(0, NT - 1)] : NI'($urandom);
        end
        out_ready = ($urandom_range(0, 2) != 0);
        prev = n_acc;
        cycle();
        pending = in_valid && (n_acc == prev);
      end
      drain_out(50);
    end
    check("final_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pla_pipe_eval.md
Name: pla_pipe_eval

Overview:
- Runtime-programmable sum-of-products evaluator, the parametrised successor to the fixed two-level netlists the benchmark flow emits.
- An AND plane of N_TERMS product terms and an OR plane driving N_OUT outputs are loaded through a config port.
- Input vectors are then evaluated through a 2-stage valid/ready pipeline with per-output inversion.
- Sits between the stimulus generator and the fitness comparator, so evolved circuits can be scored in hardware without resynthesis.

Parameters:
N_IN, 12, input vector width (1..32)
N_OUT, 10, output vector width (1..32)
N_TERMS, 32, product-term count (1..64)
AW, $clog2(N_TERMS+1), config address width (derived, not overridden)

Ports:
clk  in  1  clock, all state rising-edge
rst_n  in  1  synchronous reset, active-low
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when high with cfg_valid
cfg_addr  in  AW  0..N_TERMS-1 term slot; N_TERMS = inversion register
cfg_care  in  N_IN  AND-plane care mask for literal i
cfg_pol  in  N_IN  literal polarity (1 = true literal, 0 = complement)
cfg_or  in  N_OUT  OR-plane row for term, or out_inv value at addr N_TERMS
cfg_commit  in  1  pulse: leave CFG, enter RUN
cfg_err  out  1  sticky: write to addr > N_TERMS seen
in_valid  in  1  input vector valid
in_ready  out  1  input accepted when high with in_valid
in_vec  in  N_IN  input vector
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_vec  out  N_OUT  result vector
busy  out  1  high in DRAIN, or whenever either pipeline stage holds data

Behaviour:
- Reset: rst_n sampled low at a clk edge performs the reset, whatever the state.
  - All care/pol/or rows and out_inv cleared; both stage valids cleared.
  - cfg_err cleared; state CFG.
  - Outputs: out_valid=0, out_vec=0, in_ready=0, cfg_ready=1, busy=0.
- Term evaluation: term_t = AND over i of (~care[t][i] | (in[i] == pol[t][i])). A term with care=0 is constant 1.
- Output evaluation: out[j] = (OR over t of term_t & or[t][j]) XOR out_inv[j].
- FSM states: CFG, RUN, DRAIN.
  - CFG: cfg_ready=1 and in_ready=0. A write occurs on cfg_valid.
  - CFG, out-of-range address (addr > N_TERMS): write discarded, cfg_err set.
  - CFG: cfg_commit -> RUN. If cfg_valid and cfg_commit are both high, the write lands first, then RUN.
  - RUN: cfg_ready=0.
  - RUN: cfg_valid high -> DRAIN next cycle. The request is held by the master, not accepted.
  - DRAIN: in_ready=0. Stays until both stages are empty, then -> CFG. The held write is accepted in CFG.
  - DRAIN: cfg_commit is ignored in RUN and DRAIN.
- Pipeline:
  - Stage1 registers the N_TERMS term vector.
  - Stage2 registers out_vec.
  - Stage2 loads when empty or when out_ready && out_valid.
  - Stage1 advances under the same rule, applied to stage2.
  - in_ready = (state==RUN) && (!s1_valid || s1 advancing).
- Latency and throughput:
  - Vector accepted at edge k -> out_valid high after edge k+1, i.e. 2 cycles.
  - Throughput 1 vector/cycle with out_ready tied high.
- Backpressure:
  - out_vec held stable while out_valid && !out_ready.
  - No loss, no duplication; order preserved.
  - Max 2 vectors in flight.
- Config stability: config registers are never written while any vector is in flight, guaranteed by DRAIN.
- Widths: cfg_care/cfg_pol above N_IN do not exist. Unused out_inv bits are absent.

Optional Feature:
PLA_HIT_CNT_EN
- Defined:
  - Adds output hit_cnt [15:0].
  - Increments on each out_valid && out_ready transfer where out_vec != 0.
  - Saturates at 0xFFFF; cleared by reset and on every CFG->RUN transition.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset, then write addr0 care=0x001 pol=0x000 or=0x008, commit. Send in_vec 0x000 then 0x001 -> out_vec 0x008 then 0x000, each 2 cycles after acceptance.
2. CFG: write addr N_TERMS or=0x004 only, commit, in_vec 0xABC -> out_vec 0x004 (constant-inverted output, all terms unused).
3. Term care=0x003 pol=0x002 or=0x3FF. Stream 0x000..0x003 back-to-back, out_ready=1 -> outputs 0,0,0x3FF,0 on consecutive cycles; in_ready never drops.
4. out_ready=0 for 4 cycles while offering 4 vectors:
   - Exactly 2 accepted, then in_ready=0.
   - Releasing out_ready delivers all 4 results in order, no gaps beyond the stall.
5. cfg_valid raised in RUN with 2 vectors in flight:
   - busy=1 and cfg_ready=0 until both results are taken.
   - Then CFG, write accepted the same cycle; cfg_addr=N_TERMS+1 sets cfg_err.
6. Reset mid-stream (rst_n low 1 cycle with out_valid=1) -> next cycle out_valid=0, state CFG, out_vec=0 for any input after re-commit. With PLA_HIT_CNT_EN, hit_cnt=0.
